// File: rtl/finger_pkg.sv
// Shared types and defaults for the finger region counter.
package finger_pkg;
   localparam int COORD_W_DEF = 8;
   localparam int CNT_W_DEF   = 12;

   localparam int THUMB  = 0;
   localparam int INDEX  = 1;
   localparam int MIDDLE = 2;
   localparam int RING   = 3;
   localparam int PINKY  = 4;

   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
endpackage

// File: rtl/finger_region_counter_if.sv
// Pixel stream, box bounds and report bus of the finger region counter.
interface finger_region_counter_if
   import finger_pkg::*;
#(
   parameter int N_REGIONS = 5,
   parameter int COORD_W   = COORD_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
);
   logic                         pix_valid;
   logic                         pix_data;
   logic                         pix_sof;
   logic                         palm_valid;
   logic [N_REGIONS*COORD_W-1:0] box_row_lo;
   logic [N_REGIONS*COORD_W-1:0] box_row_hi;
   logic [N_REGIONS*COORD_W-1:0] box_col_lo;
   logic [N_REGIONS*COORD_W-1:0] box_col_hi;
   logic [CNT_W-1:0]             cfg_thresh;
   logic [N_REGIONS*CNT_W-1:0]   region_count;
   logic [N_REGIONS-1:0]         region_status;
   logic                         status_valid;
   logic                         sync_err;

   modport master (
      output pix_valid, pix_data, pix_sof, palm_valid,
      output box_row_lo, box_row_hi, box_col_lo, box_col_hi, cfg_thresh,
      input  region_count, region_status, status_valid, sync_err
   );

   modport slave (
      input  pix_valid, pix_data, pix_sof, palm_valid,
      input  box_row_lo, box_row_hi, box_col_lo, box_col_hi, cfg_thresh,
      output region_count, region_status, status_valid, sync_err
   );
endinterface

// File: rtl/region_accumulator.sv
// One box: shadow bounds latched at frame start, inclusive window test,
// saturating white-pixel counter and open/closed threshold compare.
module region_accumulator
   import finger_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               en,
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] col,
   input  logic [COORD_W-1:0] row_lo_in,
   input  logic [COORD_W-1:0] row_hi_in,
   input  logic [COORD_W-1:0] col_lo_in,
   input  logic [COORD_W-1:0] col_hi_in,
   input  logic [CNT_W-1:0]   thresh_in,
   output logic [CNT_W-1:0]   count,
   output logic               is_open
);
   logic [COORD_W-1:0] row_lo, row_hi, col_lo, col_hi;
   logic [COORD_W-1:0] rlo_e, rhi_e, clo_e, chi_e;
   logic [CNT_W-1:0]   thresh;
   logic               hit;

   // The sof pixel is judged against the bounds being latched on that same beat.
   assign rlo_e = start ? row_lo_in : row_lo;
   assign rhi_e = start ? row_hi_in : row_hi;
   assign clo_e = start ? col_lo_in : col_lo;
   assign chi_e = start ? col_hi_in : col_hi;

   assign hit = en && (row >= rlo_e) && (row <= rhi_e) && (col >= clo_e) && (col <= chi_e);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_lo <= '0;
         row_hi <= '0;
         col_lo <= '0;
         col_hi <= '0;
         thresh <= '0;
         count  <= '0;
      end else if (start) begin
         row_lo <= row_lo_in;
         row_hi <= row_hi_in;
         col_lo <= col_lo_in;
         col_hi <= col_hi_in;
         thresh <= thresh_in;
         count  <= hit ? CNT_W'(1) : '0;
      end else if (hit && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign is_open = count > thresh;
endmodule

// File: rtl/finger_region_counter.sv
// Frame FSM, raster position tracking and sof sync check around an array of
// per-box accumulators; reports counts and open status once per frame.
module finger_region_counter
   import finger_pkg::*;
#(
   parameter int IMG_W     = 120,
   parameter int IMG_H     = 160,
   parameter int COORD_W   = COORD_W_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int N_REGIONS = 5
) (
   input logic                    clk,
   input logic                    rst,
   finger_region_counter_if.slave bus
);
   state_t                              state, state_nxt;
   logic [COORD_W-1:0]                  row, col, pos_row, pos_col;
   logic                                armed, sof, beat, is_last, en;
   logic                                do_report, err;
   logic [N_REGIONS-1:0][CNT_W-1:0]     counts;
   logic [N_REGIONS-1:0]                opens;

   assign sof     = bus.pix_valid & bus.pix_sof;
   assign beat    = bus.pix_valid & (bus.pix_sof | (state == SCAN));
   assign pos_row = bus.pix_sof ? '0 : row;
   assign pos_col = bus.pix_sof ? '0 : col;
   assign is_last = (pos_row == COORD_W'(IMG_H - 1)) && (pos_col == COORD_W'(IMG_W - 1));
   assign en      = beat & bus.pix_data & (bus.pix_sof ? bus.palm_valid : armed);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sof) state_nxt = is_last ? REPORT : SCAN;
         SCAN:    if (beat && is_last) state_nxt = REPORT;
         REPORT:  state_nxt = sof ? (is_last ? REPORT : SCAN) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      do_report = (state == REPORT);
      err       = (state == SCAN) && sof;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row   <= '0;
         col   <= '0;
         armed <= 1'b0;
      end else if (beat) begin
         if (sof) armed <= bus.palm_valid;
         if (pos_col == COORD_W'(IMG_W - 1)) begin
            col <= '0;
            row <= is_last ? '0 : pos_row + COORD_W'(1);
         end else begin
            col <= pos_col + COORD_W'(1);
            row <= pos_row;
         end
      end
   end

   // Counts sampled here are pre-clear even when a new sof lands in REPORT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.region_count  <= '0;
         bus.region_status <= '0;
         bus.status_valid  <= 1'b0;
         bus.sync_err      <= 1'b0;
      end else begin
         bus.status_valid <= do_report;
         bus.sync_err     <= err;
         if (do_report) begin
            bus.region_count  <= counts;
            bus.region_status <= opens;
         end
      end
   end

   for (genvar i = 0; i < N_REGIONS; i++) begin : g_reg
      region_accumulator #(.COORD_W(COORD_W), .CNT_W(CNT_W)) u_acc (
         .clk       (clk),
         .rst       (rst),
         .start     (sof),
         .en        (en),
         .row       (pos_row),
         .col       (pos_col),
         .row_lo_in (bus.box_row_lo[i*COORD_W +: COORD_W]),
         .row_hi_in (bus.box_row_hi[i*COORD_W +: COORD_W]),
         .col_lo_in (bus.box_col_lo[i*COORD_W +: COORD_W]),
         .col_hi_in (bus.box_col_hi[i*COORD_W +: COORD_W]),
         .thresh_in (bus.cfg_thresh),
         .count     (counts[i]),
         .is_open   (opens[i])
      );
   end
endmodule

// File: doc/finger_region_counter.md
Name: finger_region_counter

Overview:
- Parametrised successor to the single-frame finger identifier.
- Consumes a raster-scanned binary object image, one pixel per accepted beat.
- Counts white pixels inside N_REGIONS rectangular boxes supplied by the palm/box-generation stage.
- At end of every frame, reports per-region counts and open/closed status against a programmable threshold, then re-arms for the next frame.

Parameters:
- IMG_W, 120, pixels per row
- IMG_H, 160, rows per frame
- COORD_W, 8, row/col and box-bound width; IMG_W and IMG_H must be <= 2**COORD_W
- CNT_W, 12, per-region pixel counter width
- N_REGIONS, 5, number of boxes (index 0 thumb .. 4 pinky when 5)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel beat valid
- pix_data  in  1  object pixel (1 = white)
- pix_sof  in  1  qualifies the beat as row 0, col 0 of a frame
- palm_valid  in  1  palm found; sampled on the sof beat
- box_row_lo  in  N_REGIONS*COORD_W  packed lower row bound per region
- box_row_hi  in  N_REGIONS*COORD_W  packed upper row bound
- box_col_lo  in  N_REGIONS*COORD_W  packed lower col bound
- box_col_hi  in  N_REGIONS*COORD_W  packed upper col bound
- cfg_thresh  in  CNT_W  open threshold, shared by all regions
- region_count  out  N_REGIONS*CNT_W  final counts of last reported frame
- region_status  out  N_REGIONS  1 = finger open
- status_valid  out  1  one-cycle pulse when outputs update
- sync_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async, any state): state IDLE, row/col = 0, all counts 0, region_count 0, region_status 0, status_valid 0, sync_err 0, armed 0.
- States:
  - IDLE -> SCAN on pix_valid & pix_sof.
  - SCAN -> REPORT when the beat at row IMG_H-1, col IMG_W-1 is accepted.
  - REPORT -> SCAN if pix_valid & pix_sof in the same cycle, else IDLE.
- In IDLE/REPORT, beats without sof are dropped silently.
- Position: col increments per accepted beat; at IMG_W-1 it wraps to 0 and row increments. The sof beat is (0,0). Stalls (pix_valid=0) freeze counters.
- On the sof beat:
  - Shadow-latch all box bounds and cfg_thresh.
  - Set armed = palm_valid.
  - Clear all counts, then apply the sof pixel's own contribution.
  - Bound changes mid-frame have no effect.
- Membership: inclusive, row_lo <= row <= row_hi and col_lo <= col <= col_hi, unsigned compare. lo > hi yields an empty box.
- Accumulate: if armed & in box & pix_data, count += 1. Counts saturate at 2**CNT_W-1; no wrap.
- Report latency: last pixel accepted on edge t. On edge t+1 (REPORT):
  - region_count <= counts.
  - region_status[i] <= (count_i > thresh), strictly greater.
  - status_valid = 1 for exactly that cycle.
- If not armed: counts stay 0, status all 0, status_valid still pulses.
- Outputs hold between reports.
- pix_sof during SCAN (not at 0,0):
  - sync_err pulses on the following edge.
  - Current frame is abandoned with no report.
  - The beat restarts a new frame exactly as in IDLE.
- Back-to-back frames: a sof in the REPORT cycle starts a new frame. The report uses the pre-clear counts, so no pixels are lost.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh sof.

Decomposition:
- Package finger_pkg holds:
  - COORD_W and CNT_W defaults
  - region index constants THUMB=0, INDEX=1, MIDDLE=2, RING=3, PINKY=4
  - state enum {IDLE, SCAN, REPORT}
- Sub-module region_accumulator, instantiated N_REGIONS times. It contains:
  - shadow bound registers
  - inclusive window compare
  - saturating counter with clear/load-first-pixel control
  - threshold compare
- Top level keeps the FSM, raster counters and sync check.

Test Plan:
- IMG_W=8, IMG_H=6, box0 rows 1..2 cols 2..4, all-white frame, thresh=5 -> count0=6, status0=1, status_valid 1 cycle, 2 edges after last pixel.
- Same box, thresh=6 -> count0=6, status0=0 (strict compare); box with lo>hi -> count 0.
- CNT_W=3, box covering the whole 8x6 frame, all white -> count saturates at 7, no wrap.
- pix_sof reasserted at row 3 col 1 -> sync_err pulse; no status_valid for the aborted frame; next full frame reports normally.
- palm_valid=0 at sof, all-white frame -> status_valid pulses with all counts 0 and status 0.
- Random stalls plus box bounds changed mid-frame, followed by back-to-back frames with sof in the REPORT cycle -> counts match the model using bounds latched at sof; both frames are reported.
